ntt_out_collector: RTL and testbench



---
 rtl/ntt_out_collector.sv | 211 +++++++++++++++++++++
 tb/tb_ntt_out_collector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_out_collector.sv
// ntt_out_collector
//
// Collects one N-coefficient polynomial from the four result lanes of the NTT
// wrap core (4 coefficients per beat). It then replays the coefficients in
// natural order, one per cycle, on a valid/ready stream.
//
// Optional feature macro: NTT_COLLECT_MODQ_EN
//   When this macro is defined, each lane is conditionally reduced (v >= Q ? v - Q : v)
//   before it is stored. The reduction adds no latency.
//
// Ports:
//   clk_i                 clock, rising edge
//   rst_ni                asynchronous active-low reset
//   in_valid_i            input beat strobe
//   in_data1_i..4_i       coefficients 4k..4k+3 of beat k
//   in_mode_i             NTT(0)/INTT(1) tag, sampled on the first beat
//   clear_i               synchronous return to idle, clears overflow
//   out_valid_o/ready_i   output handshake
//   out_data_o            coefficient value
//   out_index_o           coefficient index 0..N-1
//   out_last_o            high with index N-1
//   out_mode_o            latched mode tag
//   busy_o                not idle
//   overflow_o            sticky: an input beat was dropped
module ntt_out_collector #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N      = 256,
    parameter int unsigned Q      = 3329
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic [DATA_W-1:0]    in_data1_i,
    input  logic [DATA_W-1:0]    in_data2_i,
    input  logic [DATA_W-1:0]    in_data3_i,
    input  logic [DATA_W-1:0]    in_data4_i,
    input  logic                 in_mode_i,
    input  logic                 clear_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_W-1:0]    out_data_o,
    output logic [$clog2(N)-1:0] out_index_o,
    output logic                 out_last_o,
    output logic                 out_mode_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned BW = (N > 4) ? $clog2(N / 4) : 1;

    // StPrime is the first cycle of the drain phase: it loads word 0 into the
    // prefetch register, so out_valid rises two edges after the last beat.
    typedef enum logic [1:0] {StIdle, StFill, StPrime, StDrain} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] pf_q, pf_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [AW-1:0]     out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              mode_q, mode_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] lane_raw [4];
    logic [DATA_W-1:0] lane_wr [4];
    logic              wr_en;
    logic [AW-1:0]     wr_base;
    logic [AW-1:0]     nxt_idx;

    assign lane_raw[0] = in_data1_i;
    assign lane_raw[1] = in_data2_i;
    assign lane_raw[2] = in_data3_i;
    assign lane_raw[3] = in_data4_i;

`ifdef NTT_COLLECT_MODQ_EN
    // Inputs are below 2Q, so one conditional subtract fully reduces them.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_wr[i] = (lane_raw[i] >= DATA_W'(Q)) ? lane_raw[i] - DATA_W'(Q) : lane_raw[i];
        end
    end
`else
    // Q only matters for the reduced-store build.
    logic unused_q_bits;
    assign unused_q_bits = ^Q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_wr[i] = lane_raw[i];
        end
    end
`endif

    assign wr_base = AW'({beat_q, 2'b00});

    // Buffer contents need no reset: every word is written before it is read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[wr_base + AW'(i)] <= lane_wr[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        pf_d        = pf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        wr_en       = 1'b0;
        nxt_idx     = (out_index_q == AW'(N - 1)) ? '0 : out_index_q + 1'b1;

        if (clear_i) begin
            state_d     = StIdle;
            beat_d      = '0;
            out_valid_d = 1'b0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFill: begin
                    if (in_valid_i) begin
                        wr_en = 1'b1;
                        if (state_q == StIdle) begin
                            mode_d = in_mode_i;
                        end
                        if (beat_q == BW'(N / 4 - 1)) begin
                            beat_d  = '0;
                            state_d = StPrime;
                        end else begin
                            beat_d  = beat_q + 1'b1;
                            state_d = StFill;
                        end
                    end
                end
                StPrime: begin
                    if (in_valid_i) begin
                        ovf_d = 1'b1;
                    end
                    pf_d    = mem_q[0];
                    state_d = StDrain;
                end
                StDrain: begin
                    // Includes a beat arriving with the final handshake.
                    if (in_valid_i) begin
                        ovf_d = 1'b1;
                    end
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = pf_q;
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                    end else if (out_ready_i) begin
                        out_index_d = nxt_idx;
                        if (out_last_q) begin
                            state_d     = StIdle;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            out_data_d = mem_q[nxt_idx];
                            out_last_d = (nxt_idx == AW'(N - 1));
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            pf_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pf_q        <= pf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_index_o = out_index_q;
    assign out_last_o  = out_last_q;
    assign out_mode_o  = mode_q;
    assign busy_o      = (state_q != StIdle);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ntt_out_collector.sv
// Self-checking bench for ntt_out_collector (N=256, DATA_W=16, Q=3329).
module tb_ntt_out_collector;

    localparam int NN = 256;
    localparam int QQ = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic        in_mode = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;
    logic        out_mode;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;

    ntt_out_collector #(.DATA_W(16), .N(NN), .Q(QQ)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data1_i  (d1),
        .in_data2_i  (d2),
        .in_data3_i  (d3),
        .in_data4_i  (d4),
        .in_mode_i   (in_mode),
        .clear_i     (clear),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_index_o (out_index),
        .out_last_o  (out_last),
        .out_mode_o  (out_mode),
        .busy_o      (busy),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] store_val(input logic [15:0] v);
`ifdef NTT_COLLECT_MODQ_EN
        return (v >= 16'(QQ)) ? v - 16'(QQ) : v;
`else
        return v;
`endif
    endfunction

    // Reference model: beats accumulate into pend; a completed polynomial moves
    // to exp_q and is expected on the output from exp_first onward.
    logic [15:0] pend[$];
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    int          m_beats = 0;
    logic        pend_mode = 1'b0;
    logic        exp_mode = 1'b0;
    int          exp_first = 0;
    logic        m_ovf = 1'b0;

    always @(negedge clk) begin : cmp
        logic exp_v;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_mode", out_mode, 0);
            chk("rst_busy", busy, 0);
            chk("rst_overflow", overflow, 0);
            pend.delete();
            exp_q.delete();
            m_beats = 0;
            m_ovf = 1'b0;
        end else begin
            exp_v = (exp_q.size() > 0) && (cyc >= exp_first);
            chk("busy", busy, (m_beats > 0) || (exp_q.size() > 0));
            chk("overflow", overflow, m_ovf);
            chk("out_valid", out_valid, exp_v);
            if (exp_v) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_index", out_index, NN - exp_q.size());
                chk("out_last", out_last, exp_q.size() == 1);
                chk("out_mode", out_mode, exp_mode);
            end
            if (clear) begin
                pend.delete();
                exp_q.delete();
                m_beats = 0;
                m_ovf = 1'b0;
            end else begin
                if (in_valid) begin
                    if (exp_q.size() == 0) begin
                        if (m_beats == 0) pend_mode = in_mode;
                        pend.push_back(store_val(d1));
                        pend.push_back(store_val(d2));
                        pend.push_back(store_val(d3));
                        pend.push_back(store_val(d4));
                        m_beats++;
                        if (m_beats == NN / 4) begin
                            exp_q = pend;
                            pend.delete();
                            m_beats = 0;
                            exp_mode = pend_mode;
                            exp_first = cyc + 3;
                            got.delete();
                        end
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (exp_v && out_ready) begin
                    got.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Downstream ready: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [15:0] a, b, c, d, input logic m);
        in_valid = 1'b1;
        d1 = a; d2 = b; d3 = c; d4 = d;
        in_mode = m;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic fill_seq(input int nbeats, input logic m0);
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(16'(4 * k), 16'(4 * k + 1), 16'(4 * k + 2), 16'(4 * k + 3),
                       (k == 0) ? m0 : 1'b0);
        end
    endtask

    function automatic logic [15:0] rv();
`ifdef NTT_COLLECT_MODQ_EN
        return 16'($urandom_range(0, 2 * QQ - 1));
`else
        return 16'($urandom_range(0, 65535));
`endif
    endfunction

    task automatic fill_rand(input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            tick();
            n++;
        end
        chk("drain_done", busy, 0);
    endtask

    task automatic chk_identity(input string name);
        int bad = 0;
        chk({name, "_count"}, got.size(), NN);
        for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(i)) bad++;
        chk({name, "_seq"}, bad, 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Straight fill and full-rate drain.
        rdy_mode = 0;
        fill_seq(64, 1'b0);
        wait_idle();
        chk_identity("t1");
        chk("t1_overflow", overflow, 0);

        // Backpressure 1,0,0,1.
        rdy_mode = 1;
        fill_seq(64, 1'b0);
        wait_idle();
        chk_identity("t2");

        // Beat during drain is dropped and flagged; clear resets the flag.
        rdy_mode = 2;
        fill_seq(64, 1'b0);
        repeat (20) tick();
        drive_beat(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b1);
        wait_idle();
        chk_identity("t3");
        chk("t3_overflow_set", overflow, 1);
        pulse_clear();
        chk("t3_overflow_clr", overflow, 0);
        chk("t3_busy_clr", busy, 0);

        // Reset in the middle of a fill.
        rdy_mode = 0;
        fill_seq(30, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4_busy_async", busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        fill_seq(64, 1'b0);
        wait_idle();
        chk_identity("t4");

        // Reduction boundary values in the first beat.
        drive_beat(16'd3328, 16'd3329, 16'd4000, 16'd0, 1'b0);
        fill_rand(0);
        for (int k = 1; k < 64; k++) begin
            drive_beat(16'(4 * k), 16'(4 * k + 1), 16'(4 * k + 2), 16'(4 * k + 3), 1'b0);
        end
        wait_idle();
`ifdef NTT_COLLECT_MODQ_EN
        chk("t5_w0", got[0], 3328);
        chk("t5_w1", got[1], 0);
        chk("t5_w2", got[2], 671);
        chk("t5_w3", got[3], 0);
`else
        chk("t5_w0", got[0], 3328);
        chk("t5_w1", got[1], 3329);
        chk("t5_w2", got[2], 4000);
        chk("t5_w3", got[3], 0);
`endif
        chk("t5_w4", got[4], 4);
        chk("t5_w255", got[255], 255);

        // Mode sampled only on the first beat.
        fill_seq(64, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t6_mode", out_mode, 1);
        wait_idle();

        // Clear wins over a simultaneous beat.
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        in_valid = 1'b0;
        clear = 1'b0;
        chk("t7_clear_wins", busy, 0);

        // Randomized polynomials with aborts and stray beats.
        for (int p = 0; p < 8; p++) begin
            rdy_mode = 2;
            if (p == 2) begin
                fill_rand($urandom_range(1, 60));
                pulse_clear();
                chk("rand_abort_busy", busy, 0);
            end
            fill_rand(64);
            if (p == 5) begin
                repeat (100) tick();
                pulse_clear();
                chk("rand_drain_abort", busy, 0);
            end else begin
                if (p % 2 == 1) begin
                    repeat ($urandom_range(3, 200)) tick();
                    drive_beat(rv(), rv(), rv(), rv(), 1'b1);
                end
                wait_idle();
                chk("rand_count", got.size(), NN);
                if (overflow) pulse_clear();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
